// File: rtl/divmod_pkg.sv
// Shared types and helpers for the multi-cycle divider (divmod_unit, divmod_core).
// The optional floored-division mode is selected by the DIVMOD_FLOOR_MOD_EN macro.
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ITER,
    FIX
  } state_t;

  localparam logic SEL_QUO = 1'b0;
  localparam logic SEL_REM = 1'b1;

  // Widest operand abs_val can handle; callers pass zero-extended values.
  localparam int DIVMOD_MAX_W = 64;
  typedef logic [DIVMOD_MAX_W-1:0] wide_t;

  // Magnitude of a WIDTH-bit operand held zero-extended in a wide_t; msb is WIDTH-1.
  // Only the low WIDTH bits of the result are meaningful.
  function automatic wide_t abs_val(input wide_t value, input logic [5:0] msb,
                                    input logic signed_en);
    return (signed_en && value[msb]) ? -value : value;
  endfunction

endpackage

// File: rtl/divmod_core.sv
// Unsigned restoring-division datapath: one quotient bit per step, quotient
// bits shifted into the dividend register as it empties.
module divmod_core
  import divmod_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  // The shifted remainder needs WIDTH+1 bits; when it is >= divisor the true
  // difference is < divisor, so the low WIDTH bits of the subtraction are exact.
  assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - dvs_q;

  assign quo  = dvd_q;
  assign rem  = rem_q;
  assign last = (cnt_q == CNT_W'(1));

  // NOTE: the datapath registers are plain flops, not a memory, so they take
  // the async reset like everything else; that keeps outputs deterministic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      dvd_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(WIDTH);
    end else if (step) begin
      rem_q <= ge ? rem_sub : rem_sh[WIDTH-1:0];
      dvd_q <= {dvd_q[WIDTH-2:0], ge};
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/divmod_unit.sv
// Multi-cycle signed/unsigned divider returning quotient or remainder with ALU flags.
// Define DIVMOD_FLOOR_MOD_EN for floored signed division (remainder takes divisor sign).
module divmod_unit
  import divmod_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_en,
  input  logic             sel_rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam logic [5:0]       MSB     = 6'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             signed_r, sel_r, q_neg, r_neg, dbz_path, ovf_r;
  logic             sa, sb;
  wide_t            a_mag_w, b_mag_w;
  logic [WIDTH-1:0] quo, rem, q_c, r_c, res_c;
  logic             core_load, core_step, core_last;
  logic             unused_mag_hi;

  assign a_mag_w       = abs_val(wide_t'(a_r), MSB, signed_r);
  assign b_mag_w       = abs_val(wide_t'(b_r), MSB, signed_r);
  assign unused_mag_hi = ^{a_mag_w[DIVMOD_MAX_W-1:WIDTH], b_mag_w[DIVMOD_MAX_W-1:WIDTH]};

  assign sa        = signed_r & a_r[WIDTH-1];
  assign sb        = signed_r & b_r[WIDTH-1];
  assign core_load = (state == SETUP) && (b_r != '0);
  assign core_step = (state == ITER);
  assign C         = 1'b0;

  divmod_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (core_load),
    .step    (core_step),
    .dividend(a_mag_w[WIDTH-1:0]),
    .divisor (b_mag_w[WIDTH-1:0]),
    .quo     (quo),
    .rem     (rem),
    .last    (core_last)
  );

  // NOTE: every variable gets a value before any conditional update, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    q_c = q_neg ? -quo : quo;
    r_c = r_neg ? -rem : rem;
`ifdef DIVMOD_FLOOR_MOD_EN
    if (signed_r && q_neg && (r_c != '0)) begin
      r_c = r_c + b_r;
      q_c = q_c - WIDTH'(1);
    end
`endif
    if (dbz_path) begin
      q_c = '1;
      r_c = a_r;
    end
    res_c = (sel_r == SEL_REM) ? r_c : q_c;
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      signed_r <= 1'b0;
      sel_r    <= SEL_QUO;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dbz_path <= 1'b0;
      ovf_r    <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
      Z        <= 1'b0;
      N        <= 1'b0;
      V        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            signed_r <= signed_en;
            sel_r    <= sel_rem;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          dbz_path <= (b_r == '0);
          q_neg    <= sa ^ sb;
          r_neg    <= sa;
          ovf_r    <= signed_r && (a_r == MIN_VAL) && (b_r == '1);
          state    <= (b_r == '0) ? FIX : ITER;
        end
        ITER: begin
          if (core_last) state <= FIX;
        end
        FIX: begin
          result <= res_c;
          Z      <= (res_c == '0);
          N      <= res_c[WIDTH-1];
          V      <= dbz_path | ovf_r;
          dbz    <= dbz_path;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divmod_unit.sv
// Directed self-checking bench for divmod_unit (WIDTH=16), truncating or
// floored expectations depending on DIVMOD_FLOOR_MOD_EN.
module tb_divmod_unit;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             signed_en = 1'b0;
  logic             sel_rem = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] result;
  logic             busy, done, dbz, Z, N, C, V;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divmod_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_en(signed_en), .sel_rem(sel_rem),
    .a(a), .b(b), .result(result), .busy(busy), .done(done), .dbz(dbz),
    .Z(Z), .N(N), .C(C), .V(V)
  );

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sgn, input logic srem, output int cyc);
    @(negedge clk);
    a = av; b = bv; signed_en = sgn; sel_rem = srem; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
    checks++; if ({busy, done, dbz, Z, N, C, V} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000000", {busy, done, dbz, Z, N, C, V}); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int cyc;
    run_op(16'd100, 16'd7, 1'b0, 1'b0, cyc);
    checks++; if (result !== 16'd14) begin errors++; $display("FAIL u_quo: got %h want %h", result, 16'd14); end
    checks++; if (cyc !== 18) begin errors++; $display("FAIL u_latency: got %0d want 18", cyc); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || result !== 16'd14) begin errors++; $display("FAIL u_done_pulse: done=%b result=%h want 0/000e", done, result); end
    run_op(16'd100, 16'd7, 1'b0, 1'b1, cyc);
    checks++; if (result !== 16'd2) begin errors++; $display("FAIL u_rem: got %h want 0002", result); end
    checks++; if ({Z, N, V, dbz} !== 4'b0000) begin errors++; $display("FAIL u_rem_flags: ZNV dbz got %b want 0000", {Z, N, V, dbz}); end
    run_op(16'hFFFF, 16'h8001, 1'b0, 1'b0, cyc);
    checks++; if (result !== 16'h0001) begin errors++; $display("FAIL u_big_quo: got %h want 0001", result); end
    run_op(16'hFFFF, 16'h8001, 1'b0, 1'b1, cyc);
    checks++; if (result !== 16'h7FFE) begin errors++; $display("FAIL u_big_rem: got %h want 7ffe", result); end
    run_op(16'd5, 16'd7, 1'b0, 1'b0, cyc);
    checks++; if (result !== 16'h0000 || Z !== 1'b1) begin errors++; $display("FAIL u_zero_quo: result=%h Z=%b want 0000/1", result, Z); end
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, cyc);
    checks++; if (result !== 16'hFFFF || N !== 1'b1 || V !== 1'b0) begin errors++; $display("FAIL u_div1: result=%h N=%b V=%b want ffff/1/0", result, N, V); end
  endtask

  task automatic test_signed();
    int cyc;
    logic [WIDTH-1:0] exp_q, exp_r;
`ifdef DIVMOD_FLOOR_MOD_EN
    exp_q = 16'hFFFC; exp_r = 16'h0001;
`else
    exp_q = 16'hFFFD; exp_r = 16'hFFFF;
`endif
    run_op(16'hFFF9, 16'd2, 1'b1, 1'b0, cyc);
    checks++; if (result !== exp_q || N !== 1'b1) begin errors++; $display("FAIL s_neg7_by2_quo: result=%h N=%b want %h/1", result, N, exp_q); end
    checks++; if (cyc !== 18) begin errors++; $display("FAIL s_latency: got %0d want 18", cyc); end
    run_op(16'hFFF9, 16'd2, 1'b1, 1'b1, cyc);
    checks++; if (result !== exp_r || N !== exp_r[WIDTH-1]) begin errors++; $display("FAIL s_neg7_by2_rem: result=%h N=%b want %h", result, N, exp_r); end
`ifdef DIVMOD_FLOOR_MOD_EN
    exp_q = 16'hFFFC; exp_r = 16'hFFFF;
`else
    exp_q = 16'hFFFD; exp_r = 16'h0001;
`endif
    run_op(16'd7, 16'hFFFE, 1'b1, 1'b0, cyc);
    checks++; if (result !== exp_q) begin errors++; $display("FAIL s_7_byneg2_quo: got %h want %h", result, exp_q); end
    run_op(16'd7, 16'hFFFE, 1'b1, 1'b1, cyc);
    checks++; if (result !== exp_r) begin errors++; $display("FAIL s_7_byneg2_rem: got %h want %h", result, exp_r); end
    run_op(16'hFFF9, 16'hFFFE, 1'b1, 1'b0, cyc);
    checks++; if (result !== 16'h0003) begin errors++; $display("FAIL s_both_neg_quo: got %h want 0003", result); end
    run_op(16'hFFF9, 16'hFFFE, 1'b1, 1'b1, cyc);
    checks++; if (result !== 16'hFFFF) begin errors++; $display("FAIL s_both_neg_rem: got %h want ffff", result); end
    run_op(16'hFFF8, 16'd2, 1'b1, 1'b1, cyc);
    checks++; if (result !== 16'h0000 || Z !== 1'b1) begin errors++; $display("FAIL s_exact_rem: result=%h Z=%b want 0000/1", result, Z); end
  endtask

  task automatic test_dbz();
    int cyc;
    run_op(16'h1234, 16'h0000, 1'b0, 1'b0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL dbz_latency: got %0d want 2", cyc); end
    checks++; if (result !== 16'hFFFF) begin errors++; $display("FAIL dbz_quo: got %h want ffff", result); end
    checks++; if (dbz !== 1'b1 || V !== 1'b1) begin errors++; $display("FAIL dbz_flags: dbz=%b V=%b want 1/1", dbz, V); end
    run_op(16'h1234, 16'h0000, 1'b0, 1'b1, cyc);
    checks++; if (result !== 16'h1234 || dbz !== 1'b1 || V !== 1'b1) begin errors++; $display("FAIL dbz_rem: result=%h dbz=%b V=%b want 1234/1/1", result, dbz, V); end
  endtask

  task automatic test_overflow();
    int cyc;
    run_op(16'h8000, 16'hFFFF, 1'b1, 1'b0, cyc);
    checks++; if (result !== 16'h8000) begin errors++; $display("FAIL ovf_quo: got %h want 8000", result); end
    checks++; if (V !== 1'b1 || dbz !== 1'b0 || N !== 1'b1) begin errors++; $display("FAIL ovf_quo_flags: V=%b dbz=%b N=%b want 1/0/1", V, dbz, N); end
    run_op(16'h8000, 16'hFFFF, 1'b1, 1'b1, cyc);
    checks++; if (result !== 16'h0000 || Z !== 1'b1 || V !== 1'b1) begin errors++; $display("FAIL ovf_rem: result=%h Z=%b V=%b want 0000/1/1", result, Z, V); end
  endtask

  task automatic test_handshake();
    int cyc;
    int extra;
    @(negedge clk);
    a = 16'd100; b = 16'd7; signed_en = 1'b0; sel_rem = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 16'd1000; b = 16'd3; sel_rem = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy: got %b want 1", busy); end
    wait_done(cyc);
    checks++; if (cyc + 5 !== 18 || result !== 16'd14) begin errors++; $display("FAIL hs_ignore: cycles=%0d result=%h want 18/000e", cyc + 5, result); end
    // Second operation requested in the done cycle itself.
    a = 16'd1000; b = 16'd3; sel_rem = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    checks++; if (cyc !== 18 || result !== 16'd1) begin errors++; $display("FAIL hs_b2b: cycles=%0d result=%h want 18/0001", cyc, result); end
    extra = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++; if (extra !== 0 || busy !== 1'b0) begin errors++; $display("FAIL hs_no_extra_done: extra=%0d busy=%b want 0/0", extra, busy); end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    int extra;
    run_op(16'd100, 16'd7, 1'b0, 1'b0, cyc);
    @(negedge clk);
    a = 16'd1000; b = 16'd3; sel_rem = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (result !== 16'h0000 || {busy, done, dbz, Z, N, V} !== 6'b0) begin errors++; $display("FAIL rst_mid_op: result=%h flags=%b want 0000/000000", result, {busy, done, dbz, Z, N, V}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rst_no_done: %0d stray cycles want 0", extra); end
    run_op(16'd1000, 16'd3, 1'b0, 1'b0, cyc);
    checks++; if (result !== 16'd333 || cyc !== 18) begin errors++; $display("FAIL rst_recover: result=%h cycles=%0d want 014d/18", result, cyc); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_overflow();
    test_handshake();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
